fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

- Round-robin arbiter that shares the write port of the asynchronous FIFO between NUM_REQ requesters in the write clock domain.
- Grants one requester at a time for a bounded burst and forwards its data onto w_en/w_data.
- Throttles every transfer on the FIFO's registered w_full flag, so no write is ever presented to a full FIFO.
- Sits directly in front of the FIFO write-side logic and shares its clock and reset.

## Interface

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, FIFO word width.
- BURST_LEN, 4, maximum words per grant (1..255).
- ID_W, $clog2(NUM_REQ), width of grant_id.

Ports:
- w_clk  input  1  write-domain clock, all logic on rising edge.
- wrst_n  input  1  reset, asynchronous assert, active-low.
- req_valid  input  NUM_REQ  per-requester word valid.
- req_data  input  NUM_REQ*DATA_WIDTH  packed words; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  input  NUM_REQ  marks the last word of a requester's packet.
- req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
- w_full  input  1  FIFO full flag (registered in the FIFO write block).
- w_en  output  1  FIFO write enable.
- w_data  output  DATA_WIDTH  FIFO write data.
- grant_id  output  ID_W  index of the current grantee; valid while busy=1.
- busy  output  1  high in GRANT.

## Operation

- Handshake: a word transfers on a rising edge where req_valid[i] & req_ready[i] = 1.

FSM states:
- IDLE
  - If any req_valid bit is set, select the first set bit searching upward from last_grant+1, modulo NUM_REQ.
  - Register the selection into grant_id, clear burst_cnt, go to GRANT.
  - With no request, stay in IDLE.
- GRANT, requester g
  - req_ready[g] = !w_full; all other req_ready bits are 0.
  - w_en = req_valid[g] & !w_full.
  - w_data = req_data[g], combinational.
  - On each transfer, burst_cnt increments (8-bit, never exceeds BURST_LEN).
  - Release (go to IDLE, last_grant <= g) on whichever comes first:
    - transfer with req_last[g] = 1;
    - transfer that makes burst_cnt = BURST_LEN;
    - a cycle with req_valid[g] = 0 and w_full = 0.
- While w_full = 1 in GRANT: hold the grant, w_en = 0, burst_cnt frozen. There is no timeout.
- Requesters keep req_data/req_last stable while req_valid is high and not accepted.
- Outside GRANT: w_en = 0, req_ready = 0, w_data = 0.

Reset (wrst_n low, any time, including mid-burst):
- state = IDLE, busy = 0, grant_id = 0, burst_cnt = 0, w_en = 0, req_ready = 0, w_data = 0.
- last_grant = NUM_REQ-1, so requester 0 wins first.
- An in-flight burst is abandoned; no partial-word effects.

## Timing

- Arbitration latency: req_valid rising at edge k in IDLE gives busy = 1 and grant_id valid after edge k+1. The first w_en is in cycle k+1 if w_full = 0.
- Throughput in GRANT: one word per cycle while w_full = 0.
- Release gap: one IDLE bubble cycle between consecutive grants. Releasing at edge r allows the next grant at edge r+1 and its first w_en in cycle r+1.
- Peak sustained rate with all requesters active: BURST_LEN/(BURST_LEN+1) words per cycle.
- w_full reaction: zero cycles; w_en and req_ready drop combinationally in the same cycle w_full is high.

## Configuration

- FIFO_WR_ARB_STATS_EN
  - Defined: adds output wr_count (16-bit) and registered output stall_cnt (16-bit).
    - wr_count counts every w_en cycle, saturating at 16'hFFFF.
    - stall_cnt counts GRANT cycles with req_valid[g] & w_full, saturating at 16'hFFFF.
    - Both reset to 0.
  - Undefined: neither port nor counter exists; all other behaviour is identical.

## Test plan

- Single requester: req_valid[2] = 1 continuously, 6-word packet with last on word 6, BURST_LEN = 4.
  - Grant 2, w_en for 4 cycles, 1 IDLE cycle, grant 2 again, 2 more words.
  - w_data sequence matches the input order exactly.
- All 4 requesters valid after reset, BURST_LEN = 4:
  - grant_id sequence 0,1,2,3,0.
  - Each burst is 4 writes, with exactly 1 bubble cycle between grants.
- w_full asserted for 3 cycles mid-burst (after word 2, requester 1):
  - w_en = 0 and req_ready[1] = 0 for those 3 cycles.
  - Grant held, words 3..4 follow; total writes = 4, none lost or duplicated.
- Requester 3 drops req_valid after 1 word, no last:
  - Released next cycle, last_grant = 3.
  - A pending requester 0 is granted on the following cycle.
- wrst_n pulsed low for 1 cycle mid-burst:
  - All outputs are 0 asynchronously.
  - After release, requester 0 wins even if requester 2 was previously granted.
- With FIFO_WR_ARB_STATS_EN defined: 10 writes plus 3 stalled cycles give wr_count = 10, stall_cnt = 3. Reset clears both.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter sharing the async FIFO write port
//
// Grants one of NUM_REQ write-domain requesters at a time for a burst of at
// most BURST_LEN words and forwards its words onto w_en/w_data. Every
// transfer is throttled combinationally by the FIFO's registered w_full flag.
//
// Ports:
//   w_clk      write-domain clock (rising edge)
//   wrst_n     asynchronous active-low reset
//   req_valid  per-requester word valid
//   req_data   packed words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last   per-requester last-word-of-packet marker
//   req_ready  per-requester accept (one-hot or zero)
//   w_full     FIFO full flag
//   w_en       FIFO write enable
//   w_data     FIFO write data
//   wr_count   writes issued, saturating (FIFO_WR_ARB_STATS_EN only)
//   stall_cnt  granted cycles blocked by w_full, saturating (FIFO_WR_ARB_STATS_EN only)
//   grant_id   current grantee, valid while busy
//   busy       high while a grant is active
//
// Optional feature macro: FIFO_WR_ARB_STATS_EN

module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          w_clk,
    input  logic                          wrst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          w_full,
    output logic                          w_en,
    output logic [DATA_WIDTH-1:0]         w_data,
    output logic [ID_W-1:0]               grant_id,
`ifdef FIFO_WR_ARB_STATS_EN
    output logic [15:0]                   wr_count,
    output logic [15:0]                   stall_cnt,
`endif
    output logic                          busy
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] grant_nxt;
    logic [ID_W-1:0] last_grant, last_grant_nxt;
    logic [7:0]      burst_cnt, burst_cnt_nxt;
    logic [ID_W-1:0] sel_id;
    logic [ID_W-1:0] cand;
    logic            sel_found;
    logic            g_valid;
    logic            g_last;

    logic [DATA_WIDTH-1:0] req_words [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_words[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    assign g_valid = req_valid[grant_id];
    assign g_last  = req_last[grant_id];

    // Round-robin search: first valid requester strictly after last_grant,
    // wrapping modulo NUM_REQ; last_grant itself is checked last.
    always_comb begin
        sel_id    = '0;
        sel_found = 1'b0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ID_W'((int'(last_grant) + i) % NUM_REQ);
            if (!sel_found && req_valid[cand]) begin
                sel_found = 1'b1;
                sel_id    = cand;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant_id;
        last_grant_nxt = last_grant;
        burst_cnt_nxt  = burst_cnt;
        busy           = 1'b0;
        w_en           = 1'b0;
        req_ready      = '0;
        w_data         = '0;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    grant_nxt     = sel_id;
                    burst_cnt_nxt = 8'd0;
                    state_nxt     = GRANT;
                end
            end
            GRANT: begin
                busy                = 1'b1;
                req_ready[grant_id] = !w_full;
                w_data              = req_words[grant_id];
                w_en                = g_valid && !w_full;
                if (w_en) begin
                    burst_cnt_nxt = burst_cnt + 8'd1;
                    if (g_last || burst_cnt_nxt == 8'(BURST_LEN)) begin
                        state_nxt      = IDLE;
                        last_grant_nxt = grant_id;
                    end
                end else if (!g_valid && !w_full) begin
                    // Requester went quiet: give the port to someone else.
                    // A full FIFO never causes release; the grant is held.
                    state_nxt      = IDLE;
                    last_grant_nxt = grant_id;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge w_clk or negedge wrst_n) begin
        if (!wrst_n) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
            burst_cnt  <= 8'd0;
        end else begin
            state      <= state_nxt;
            grant_id   <= grant_nxt;
            last_grant <= last_grant_nxt;
            burst_cnt  <= burst_cnt_nxt;
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    always_ff @(posedge w_clk or negedge wrst_n) begin
        if (!wrst_n) begin
            wr_count  <= 16'd0;
            stall_cnt <= 16'd0;
        end else begin
            if (w_en && wr_count != 16'hFFFF) begin
                wr_count <= wr_count + 16'd1;
            end
            if (state == GRANT && g_valid && w_full && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter

module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int BL = 4;

    logic             clk;
    logic             wrst_n;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_last;
    logic [NR-1:0]    req_ready;
    logic             w_full;
    logic             w_en;
    logic [DW-1:0]    w_data;
    logic [1:0]       grant_id;
    logic             busy;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0]      wr_count;
    logic [15:0]      stall_cnt;
`endif

    fifo_wr_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_LEN(BL), .ID_W(2)
    ) dut (
        .w_clk(clk), .wrst_n(wrst_n),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .w_full(w_full), .w_en(w_en), .w_data(w_data),
        .grant_id(grant_id),
`ifdef FIFO_WR_ARB_STATS_EN
        .wr_count(wr_count), .stall_cnt(stall_cnt),
`endif
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic       w_en;
        logic [1:0] id;
        logic [3:0] valid;
    } tr_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          wr_seen = 0;
    int          n_pushed = 0;
    int          n_popped = 0;
    logic [31:0] exp_q[$];
    logic [8:0]  src_q[NR][$];
    tr_t         trace[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Requester models: pop on the handshake sampled mid-cycle, re-drive just after the edge.
    initial begin
        logic [NR-1:0] acc;
        logic [8:0]    head;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    head = src_q[i][0];
                    req_valid[i]        = 1'b1;
                    req_data[i*DW +: DW] = head[7:0];
                    req_last[i]         = head[8];
                end else begin
                    req_valid[i]        = 1'b0;
                    req_data[i*DW +: DW] = '0;
                    req_last[i]         = 1'b0;
                end
            end
        end
    end

    // Monitor: cycle trace plus scoreboard comparison of every FIFO write.
    always @(negedge clk) begin
        logic [31:0] e;
        trace.push_back('{busy: busy, w_en: w_en, id: grant_id, valid: req_valid});
        if (w_en) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                check("sb_overrun", n_popped + 1, n_pushed);
            end else begin
                e = exp_q.pop_front();
                n_popped++;
                check("sb_word", {22'd0, grant_id, w_data}, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic load(input int i, input int base, input int n, input bit with_last);
        for (int j = 0; j < n; j++)
            src_q[i].push_back({(with_last && j == n - 1), 8'(base + j)});
    endtask

    task automatic push_exp(input int id, input int base, input int start, input int n);
        for (int j = start; j < start + n; j++) begin
            exp_q.push_back(32'((id << 8) | ((base + j) & 255)));
            n_pushed++;
        end
    endtask

    task automatic wait_writes(input int n);
        int cyc = 0;
        while (wr_seen < n && cyc < 400) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        check("wait_writes", wr_seen, (wr_seen >= n) ? wr_seen : n);
    endtask

    task automatic check_zero(input string tag);
        check(tag, {busy, w_en, req_ready, w_data, grant_id}, 0);
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #2;
        wrst_n = 1'b0;
        for (int i = 0; i < NR; i++) src_q[i].delete();
        #1;
        check_zero("reset_outputs");
        @(posedge clk);
        #2;
        wrst_n = 1'b1;
        @(posedge clk);
        #2;
        wr_seen = 0;
        trace.delete();
    endtask

    function automatic int find_valid();
        for (int k = 0; k < trace.size(); k++)
            if (trace[k].valid != 0) return k;
        return -1;
    endfunction

    function automatic int find_wen();
        for (int k = 0; k < trace.size(); k++)
            if (trace[k].w_en) return k;
        return -1;
    endfunction

    task automatic exp_grant(inout int p, input int id, input int n, input string tag);
        for (int j = 0; j < n; j++) begin
            if (p >= trace.size()) check({tag, "_short"}, p, trace.size() - 1);
            else check(tag, {trace[p].busy, trace[p].w_en, trace[p].id}, {1'b1, 1'b1, 2'(id)});
            p++;
        end
    endtask

    task automatic exp_idle(inout int p, input string tag);
        if (p >= trace.size()) check({tag, "_short"}, p, trace.size() - 1);
        else check(tag, {trace[p].busy, trace[p].w_en}, 0);
        p++;
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #2;
        check("sb_drained", exp_q.size(), 0);
    endtask

    initial begin
        int p;
        wrst_n = 1'b0;
        w_full = 1'b0;
        #3;
        check_zero("por_outputs");
        reset_dut();

        // Single requester 2: 6-word packet split 4 + 2 with one bubble.
        load(2, 8'h10, 6, 1'b1);
        push_exp(2, 8'h10, 0, 6);
        wait_writes(6);
        settle();
        p = find_valid();
        if (p < 0) check("t1_find", p, 0);
        else begin
            check("t1_latency_idle", trace[p].busy, 0);
            p++;
            exp_grant(p, 2, 4, "t1_burst_a");
            exp_idle(p, "t1_bubble");
            exp_grant(p, 2, 2, "t1_burst_b");
            exp_idle(p, "t1_release");
        end
        check("t1_writes", wr_seen, 6);

        // All four requesters: round robin 0,1,2,3,0 with one bubble each.
        reset_dut();
        for (int i = 0; i < NR; i++) load(i, 8'h40 + 16 * i, 8, 1'b1);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NR; i++) push_exp(i, 8'h40 + 16 * i, 4 * r, 4);
        wait_writes(32);
        settle();
        p = find_valid();
        if (p < 0) check("t2_find", p, 0);
        else begin
            check("t2_latency_idle", trace[p].busy, 0);
            p++;
            for (int k = 0; k < 5; k++) begin
                exp_grant(p, k % NR, 4, "t2_burst");
                exp_idle(p, "t2_bubble");
            end
        end

        // w_full held 3 cycles after word 2 of requester 1.
        reset_dut();
        load(1, 8'hA0, 4, 1'b1);
        push_exp(1, 8'hA0, 0, 4);
        wait_writes(2);
        w_full = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t3_full_wen", w_en, 0);
            check("t3_full_ready", req_ready, 0);
            check("t3_full_hold", {busy, grant_id}, 3'b101);
        end
        @(posedge clk);
        #2;
        w_full = 1'b0;
        wait_writes(4);
        settle();
        check("t3_writes", wr_seen, 4);

        // Requester 3 goes quiet after one word; pending requester 0 follows.
        reset_dut();
        load(3, 8'hC0, 1, 1'b0);
        push_exp(3, 8'hC0, 0, 1);
        wait_writes(1);
        load(0, 8'hD0, 1, 1'b1);
        push_exp(0, 8'hD0, 0, 1);
        wait_writes(2);
        settle();
        p = find_wen();
        if (p < 0) check("t4_find", p, 0);
        else begin
            check("t4_first_id", trace[p].id, 3);
            p++;
            if (p + 2 >= trace.size()) check("t4_short", p + 2, trace.size() - 1);
            else begin
                check("t4_hold_noword", {trace[p].busy, trace[p].w_en, trace[p].id}, 4'b1011);
                check("t4_bubble", {trace[p+1].busy, trace[p+1].w_en}, 0);
                check("t4_next_grant", {trace[p+2].busy, trace[p+2].w_en, trace[p+2].id}, 4'b1100);
            end
        end

        // Reset pulse mid-burst of requester 2; requester 0 must win afterwards.
        reset_dut();
        load(2, 8'h20, 6, 1'b1);
        push_exp(2, 8'h20, 0, 2);
        wait_writes(2);
        wrst_n = 1'b0;
        load(0, 8'h30, 2, 1'b1);
        push_exp(0, 8'h30, 0, 2);
        push_exp(2, 8'h20, 2, 4);
        #1;
        check_zero("t5_async_reset");
        @(posedge clk);
        #2;
        wrst_n = 1'b1;
        wait_writes(8);
        settle();
        check("t5_writes", wr_seen, 8);

`ifdef FIFO_WR_ARB_STATS_EN
        reset_dut();
        check("t6_wr_count_rst", wr_count, 0);
        check("t6_stall_rst", stall_cnt, 0);
        load(1, 8'h80, 10, 1'b1);
        push_exp(1, 8'h80, 0, 10);
        wait_writes(2);
        w_full = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        w_full = 1'b0;
        wait_writes(10);
        settle();
        check("t6_wr_count", wr_count, 10);
        check("t6_stall_cnt", stall_cnt, 3);
        reset_dut();
        check("t6_wr_count_clr", wr_count, 0);
        check("t6_stall_clr", stall_cnt, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
